tap_ctrl: RTL
=============

// Module: tap_ctrl
// PURPOSE
// - IEEE 1149.1-style TAP controller: 16-state TMS-driven FSM, instruction register (IR) with decode,
//   BYPASS and IDCODE data registers, and the TDO output mux.
// - Sits directly upstream of the boundary-scan register: drives its dr_shift/dr_capture/dr_update,
//   bsr_select and mode inputs, and consumes its serial output (bsr_tdo).
// PARAMETERS
// - IR_WIDTH    4             instruction register width
// - IDCODE_VAL  32'h0000_0001 device ID; bit0 must be 1
// PORTS
// - TCK               input   1         test clock; all state updates on rising edge
// - TRST              input   1         reset; synchronous, active-high
// - TMS               input   1         mode select; sampled on each TCK rising edge
// - TDI               input   1         serial data in
// - bsr_tdo           input   1         serial output of the boundary-scan register
// - TDO               output  1         serial data out (combinational mux, see BEHAVIOUR)
// - dr_capture        output  1         FSM in CAPTURE_DR
// - dr_shift          output  1         FSM in SHIFT_DR
// - dr_update         output  1         FSM in UPDATE_DR
// - bsr_select        output  1         current instruction is EXTEST or SAMPLE_PRELOAD
// - mode              output  1         current instruction is EXTEST; BSR drives pins
// - tlr_reset         output  1         FSM in TEST_LOGIC_RESET
// - ir_out            output  IR_WIDTH  current (updated) instruction
// BEHAVIOUR
// - FSM: next state = f(state, TMS) on every TCK edge. Transitions given as (TMS=0 / TMS=1):
//   TLR(RTI/TLR); RTI(RTI/SEL_DR); SEL_DR(CAP_DR/SEL_IR); CAP_DR(SH_DR/EX1_DR); SH_DR(SH_DR/EX1_DR);
//   EX1_DR(PAU_DR/UPD_DR); PAU_DR(PAU_DR/EX2_DR); EX2_DR(SH_DR/UPD_DR); UPD_DR(RTI/SEL_DR);
//   SEL_IR(CAP_IR/TLR). The *_IR states mirror the *_DR states. TMS=1 for 5 edges reaches TLR from any state.
// - dr_*, tlr_reset: Moore outputs, decoded from the state register. Not gated by instruction; the BSR gates on bsr_select.
// - IR: separate shift register (ir_sr) and update register (ir).
//   CAP_IR: ir_sr <= {'0, 2'b01}. SH_IR: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]}, LSB first.
//   UPD_IR: ir <= ir_sr. In TLR, ir <= IDCODE every cycle.
// - Opcodes: EXTEST=4'h0, SAMPLE_PRELOAD=4'h1, IDCODE=4'h2, BYPASS=4'hF.
//   Any other opcode decodes as BYPASS. ir_out reports the raw ir value.
// - bsr_select, mode: combinational decode of ir. They change only on the edge leaving UPD_IR, or on entry to TLR.
// - BYPASS reg: cleared in CAP_DR; loads TDI in SH_DR; applies only when BYPASS is selected.
// - IDCODE reg: loads IDCODE_VAL in CAP_DR; shifts right with TDI into the MSB in SH_DR; applies only when IDCODE is selected.
// - TDO:
//   - SH_IR: ir_sr[0].
//   - SH_DR: bsr_tdo (EXTEST/SAMPLE_PRELOAD), idcode_sr[0] (IDCODE), or bypass_reg (BYPASS/unknown).
//   - All other states: 0.
// - Reset (TRST=1 at an edge), including mid-shift:
//   - state=TLR, ir=IDCODE, ir_sr=0, bypass_reg=0, idcode_sr=IDCODE_VAL.
//   - Resulting outputs: tlr_reset=1, dr_*=0, bsr_select=0, mode=0, TDO=0, ir_out=4'h2.
//   - TRST overrides TMS.
// - Latency: every output reflects the state/register value one TCK edge after the TMS/TDI sample that caused it.
// - Simultaneous events: none are possible within the same cycle, because capture, shift and update are mutually exclusive states.
// STRUCTURE
// - jtag_types_pkg: tap_state_t (16-value enum), IR_WIDTH default, opcode localparams (EXTEST, SAMPLE_PRELOAD, IDCODE, BYPASS).
// - Sub-module tap_fsm: state register, next-state logic and Moore decodes.
// - tap_ctrl itself holds the IR, BYPASS and IDCODE registers, the instruction decode and the TDO mux.
// TESTING
// - Reset, then TMS=0 x1 -> state RTI, tlr_reset=0, ir_out=4'h2, bsr_select=0.
// - From RTI, TMS=1,1,0,0 -> CAP_IR, then SH_IR. Shift TDI 0,0,0,0 with TMS=0,0,0,1, then TMS=1 (UPD_IR):
//   - TDO during the shift shows 1,0,0,0 (the captured 01 pattern).
//   - After UPD_IR: ir_out=4'h0, bsr_select=1, mode=1.
// - IDCODE_VAL=32'hA5A5_1235: enter SH_DR with IDCODE loaded, shift 32 bits -> TDO serializes 0x A5A51235 LSB first.
// - Load IR=4'h7 (unknown), then shift DR with TDI=1,0,1 -> TDO = 0,1,0 (1-bit bypass delay). bsr_select=0.
// - Load EXTEST, walk a DR scan -> dr_capture high 1 cycle, dr_shift high for N cycles, dr_update high 1 cycle. TDO follows bsr_tdo.
// - Assert TRST mid SH_DR -> next edge: TLR, dr_shift=0, ir_out=4'h2. Also from each of the 16 states, TMS=1 x5 -> TLR.

Source files
------------

// File: rtl/jtag_types_pkg.sv
// Shared types and constants for the JTAG TAP controller: the 16 TAP
// states, the default instruction width and the public opcodes.
package jtag_types_pkg;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SH_DR,
    ST_EX1_DR,
    ST_PAU_DR,
    ST_EX2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SH_IR,
    ST_EX1_IR,
    ST_PAU_IR,
    ST_EX2_IR,
    ST_UPD_IR
  } tap_state_t;

  // Which data register sits between TDI and TDO in SH_DR.
  typedef enum logic [1:0] {
    DR_BSR,
    DR_IDCODE,
    DR_BYPASS
  } dr_sel_t;

  localparam int unsigned DEFAULT_IR_WIDTH = 4;

  localparam logic [3:0] OP_EXTEST         = 4'h0;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'h1;
  localparam logic [3:0] OP_IDCODE         = 4'h2;
  localparam logic [3:0] OP_BYPASS         = 4'hF;

endpackage

// File: rtl/tap_fsm.sv
// TAP state machine: 16-state TMS-driven controller with Moore decodes.
// The next state is exported so the parent can act on entry to TLR.
module tap_fsm
  import jtag_types_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state,
  output tap_state_t next_state,
  output logic       dr_capture,
  output logic       dr_shift,
  output logic       dr_update,
  output logic       tlr_reset
);

  // State register; TRST wins over TMS.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge TCK) begin
    if (TRST) state <= ST_TLR;
    else      state <= next_state;
  end

  // Next-state logic: the standard 1149.1 transition graph.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = ST_TLR;
    unique case (state)
      ST_TLR:    next_state = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    next_state = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: next_state = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: next_state = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  next_state = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: next_state = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: next_state = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: next_state = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: next_state = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: next_state = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: next_state = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  next_state = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: next_state = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: next_state = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: next_state = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: next_state = TMS ? ST_SEL_DR : ST_RTI;
      default:   next_state = ST_TLR;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    dr_capture = (state == ST_CAP_DR);
    dr_shift   = (state == ST_SH_DR);
    dr_update  = (state == ST_UPD_DR);
    tlr_reset  = (state == ST_TLR);
  end

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller top: instruction register with decode, BYPASS and
// IDCODE data registers, and the TDO mux feeding the scan chain output.
module tap_ctrl
  import jtag_types_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = DEFAULT_IR_WIDTH,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                bsr_tdo,
  output logic                TDO,
  output logic                dr_capture,
  output logic                dr_shift,
  output logic                dr_update,
  output logic                bsr_select,
  output logic                mode,
  output logic                tlr_reset,
  output logic [IR_WIDTH-1:0] ir_out
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_t          state;
  tap_state_t          next_state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir;
  logic                bypass_reg;
  logic [31:0]         idcode_sr;
  dr_sel_t             dr_sel;

  tap_fsm u_fsm (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .state      (state),
    .next_state (next_state),
    .dr_capture (dr_capture),
    .dr_shift   (dr_shift),
    .dr_update  (dr_update),
    .tlr_reset  (tlr_reset)
  );

  // Instruction shift and update registers. IDCODE is forced both while in
  // TLR and on the edge entering it, so the decode is valid as soon as the
  // controller reports tlr_reset.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_sr <= '0;
      ir    <= IR_IDCODE;
    end else begin
      unique case (state)
        ST_CAP_IR: ir_sr <= IR_CAPTURE;
        ST_SH_IR:  ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
        ST_UPD_IR: ir    <= ir_sr;
        default:   ;
      endcase
      if (state == ST_TLR || next_state == ST_TLR) ir <= IR_IDCODE;
    end
  end

  // Instruction decode; anything not explicitly known selects BYPASS.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == IR_EXTEST || ir == IR_SAMPLE) dr_sel = DR_BSR;
    else if (ir == IR_IDCODE)               dr_sel = DR_IDCODE;
  end

  assign bsr_select = (dr_sel == DR_BSR);
  assign mode       = (ir == IR_EXTEST);
  assign ir_out     = ir;

  // BYPASS and IDCODE data registers; each only moves while it is selected.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      bypass_reg <= 1'b0;
      idcode_sr  <= IDCODE_VAL;
    end else if (state == ST_CAP_DR) begin
      if (dr_sel == DR_BYPASS) bypass_reg <= 1'b0;
      if (dr_sel == DR_IDCODE) idcode_sr  <= IDCODE_VAL;
    end else if (state == ST_SH_DR) begin
      if (dr_sel == DR_BYPASS) bypass_reg <= TDI;
      if (dr_sel == DR_IDCODE) idcode_sr  <= {TDI, idcode_sr[31:1]};
    end
  end

  // TDO mux: only the shift states drive data out, everything else is 0.
  always_comb begin
    TDO = 1'b0;
    if (state == ST_SH_IR) begin
      TDO = ir_sr[0];
    end else if (state == ST_SH_DR) begin
      unique case (dr_sel)
        DR_BSR:    TDO = bsr_tdo;
        DR_IDCODE: TDO = idcode_sr[0];
        default:   TDO = bypass_reg;
      endcase
    end
  end

endmodule
